// File: rtl/c17_pipe_array.sv
// c17_pipe_array: LANES-wide bit-sliced c17 with one register per logic level,
// path-balanced so N22/N23 share an input vector, valid/ready with global stall.
module c17_pipe_array #(
    parameter int LANES        = 8,
    parameter int EXTRA_STAGES = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] N1,
    input  logic [LANES-1:0] N2,
    input  logic [LANES-1:0] N3,
    input  logic [LANES-1:0] N6,
    input  logic [LANES-1:0] N7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] N22,
    output logic [LANES-1:0] N23,
    output logic [CNT_W-1:0] vec_cnt
);

    localparam int NO = EXTRA_STAGES + 1;

    logic             w_stall;
    logic             w_adv;

    logic             r_s1_v;
    logic [LANES-1:0] r_s1_n13;
    logic [LANES-1:0] r_s1_n16;
    logic [LANES-1:0] r_s1_n20;
    logic [LANES-1:0] r_s1_n2;

    logic             r_s2_v;
    logic [LANES-1:0] r_s2_n18;
    logic [LANES-1:0] r_s2_n23;
    logic [LANES-1:0] r_s2_n13;

    // Index 0 is S3; indices 1..EXTRA_STAGES are the plain output delays.
    logic             r_o_v   [NO];
    logic [LANES-1:0] r_o_n22 [NO];
    logic [LANES-1:0] r_o_n23 [NO];

    logic [CNT_W-1:0] r_cnt;

    assign w_stall  = out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_n13 <= '0;
            r_s1_n16 <= '0;
            r_s1_n20 <= '0;
            r_s1_n2  <= '0;
        end else if (w_adv) begin
            r_s1_v   <= in_valid;
            r_s1_n13 <= N1 & N3;
            r_s1_n16 <= N3 & N6;
            r_s1_n20 <= N2 | N7;
            r_s1_n2  <= N2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_s2_n18 <= '0;
            r_s2_n23 <= '0;
            r_s2_n13 <= '0;
        end else if (w_adv) begin
            r_s2_v   <= r_s1_v;
            r_s2_n18 <= r_s1_n2 & ~r_s1_n16;
            r_s2_n23 <= ~r_s1_n16 & r_s1_n20;
            r_s2_n13 <= r_s1_n13;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NO; i++) begin
                r_o_v[i]   <= 1'b0;
                r_o_n22[i] <= '0;
                r_o_n23[i] <= '0;
            end
        end else if (w_adv) begin
            r_o_v[0]   <= r_s2_v;
            r_o_n22[0] <= r_s2_n13 | r_s2_n18;
            r_o_n23[0] <= r_s2_n23;
            for (int i = 1; i < NO; i++) begin
                r_o_v[i]   <= r_o_v[i-1];
                r_o_n22[i] <= r_o_n22[i-1];
                r_o_n23[i] <= r_o_n23[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (out_valid & out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_o_v[EXTRA_STAGES];
    assign N22       = r_o_n22[EXTRA_STAGES];
    assign N23       = r_o_n23[EXTRA_STAGES];
    assign vec_cnt   = r_cnt;

endmodule

// File: tb/tb_c17_pipe_array.sv
// Directed bench for c17_pipe_array: default build, EXTRA_STAGES=2 build
// and CNT_W=4 build share one stimulus bus.
module tb_c17_pipe_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] n1, n2, n3, n6, n7;

    logic       a_ir, a_ov;
    logic [7:0] a22, a23;
    logic [15:0] a_cnt;
    logic       b_ir, b_ov;
    logic [7:0] b22, b23;
    logic [15:0] b_cnt;
    logic       c_ir, c_ov;
    logic [7:0] c22, c23;
    logic [3:0] c_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    c17_pipe_array #(.LANES(8), .EXTRA_STAGES(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .out_valid(a_ov), .out_ready(out_ready),
        .N22(a22), .N23(a23), .vec_cnt(a_cnt));

    c17_pipe_array #(.LANES(8), .EXTRA_STAGES(2), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .out_valid(b_ov), .out_ready(out_ready),
        .N22(b22), .N23(b23), .vec_cnt(b_cnt));

    c17_pipe_array #(.LANES(8), .EXTRA_STAGES(0), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ir),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .out_valid(c_ov), .out_ready(out_ready),
        .N22(c22), .N23(c23), .vec_cnt(c_cnt));

    // Reference c17 equations, returns {N22, N23}
    function automatic logic [15:0] c17m(input logic [7:0] a, b, c, d, e);
        logic [7:0] o22, o23;
        o22 = (a & c) | (b & ~(c & d));
        o23 = ~(c & d) & (b | e);
        return {o22, o23};
    endfunction

    task automatic drive(input logic [7:0] a, b, c, d, e, input logic v);
        n1 = a; n2 = b; n3 = c; n6 = d; n7 = e;
        in_valid = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom));
            out_ready = 1'($urandom);
            #1;
            n_vec++; if (a_ov !== 1'b0) begin n_bad++;
                $display("FAIL reset a out_valid: got %b want 0", a_ov); end
            n_vec++; if (a22 !== 8'h00 || a23 !== 8'h00) begin n_bad++;
                $display("FAIL reset a N22/N23: got %h/%h want 00/00", a22, a23); end
            n_vec++; if (a_cnt !== 16'd0) begin n_bad++;
                $display("FAIL reset a vec_cnt: got %0d want 0", a_cnt); end
            n_vec++; if ({a_ir, b_ir, c_ir} !== 3'b111) begin n_bad++;
                $display("FAIL reset in_ready: got %b want 111", {a_ir, b_ir, c_ir}); end
            n_vec++; if ({b_ov, c_ov} !== 2'b00 || b_cnt !== 16'd0 || c_cnt !== 4'd0) begin
                n_bad++;
                $display("FAIL reset b/c: got ov=%b cnt=%0d/%0d want 00 0/0",
                         {b_ov, c_ov}, b_cnt, c_cnt); end
            n_vec++; if ({b22, b23, c22, c23} !== 32'h0) begin n_bad++;
                $display("FAIL reset b/c data: got %h want 0", {b22, b23, c22, c23}); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    // 32 patterns, lane i of cycle c carries p=c*8+i as {N1,N2,N3,N6,N7}
    task automatic test_truth_table;
        logic [7:0] v1  [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] v2  [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [7:0] e22 [4] = '{8'h00, 8'h3F, 8'hF0, 8'hFF};
        logic [7:0] e23 [4] = '{8'h2A, 8'h3F, 8'h2A, 8'h3F};
        logic       ev;
        do_reset;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            ev = (c >= 3 && c <= 6);
            n_vec++; if (a_ov !== ev) begin n_bad++;
                $display("FAIL tt a out_valid c=%0d: got %b want %b", c, a_ov, ev); end
            if (ev) begin
                n_vec++; if (a22 !== e22[c-3] || a23 !== e23[c-3]) begin n_bad++;
                    $display("FAIL tt a data c=%0d: got %h/%h want %h/%h",
                             c, a22, a23, e22[c-3], e23[c-3]); end
            end
            ev = (c >= 5);
            n_vec++; if (b_ov !== ev) begin n_bad++;
                $display("FAIL tt b out_valid c=%0d: got %b want %b", c, b_ov, ev); end
            if (ev) begin
                n_vec++; if (b22 !== e22[c-5] || b23 !== e23[c-5]) begin n_bad++;
                    $display("FAIL tt b data c=%0d: got %h/%h want %h/%h",
                             c, b22, b23, e22[c-5], e23[c-5]); end
            end
            if (c < 4) drive(v1[c], v2[c], 8'hF0, 8'hCC, 8'hAA, 1'b1);
            else in_valid = 1'b0;
        end
        n_vec++; if (a_cnt !== 16'd4) begin n_bad++;
            $display("FAIL tt a vec_cnt: got %0d want 4", a_cnt); end
    endtask

    task automatic test_backpressure;
        logic [15:0] q[$];
        logic [15:0] exp;
        logic [7:0]  x1, x2, x3, x6, x7, h22, h23;
        logic        exp_ir;
        int          sent = 0;
        int          got = 0;
        h22 = 8'h00; h23 = 8'h00;
        do_reset;
        for (int c = 0; c < 60 && got < 20; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 8 && c < 13);
            x1 = 8'(sent * 37 + 1); x2 = 8'(sent * 59 + 3); x3 = 8'(sent * 23 + 7);
            x6 = 8'(sent * 91 + 5); x7 = 8'(sent * 13 + 11);
            drive(x1, x2, x3, x6, x7, sent < 20);
            #1;
            exp_ir = out_ready;
            n_vec++; if (a_ir !== exp_ir) begin n_bad++;
                $display("FAIL bp in_ready c=%0d: got %b want %b", c, a_ir, exp_ir); end
            if (!out_ready) begin
                n_vec++; if (a_ov !== 1'b1) begin n_bad++;
                    $display("FAIL bp stall out_valid c=%0d: got %b want 1", c, a_ov); end
                if (c > 8) begin
                    n_vec++; if (a22 !== h22 || a23 !== h23) begin n_bad++;
                        $display("FAIL bp hold c=%0d: got %h/%h want %h/%h",
                                 c, a22, a23, h22, h23); end
                end
            end
            if (c == 8) begin h22 = a22; h23 = a23; end
            if (in_valid && exp_ir) begin
                q.push_back(c17m(x1, x2, x3, x6, x7));
                sent++;
            end
            if (a_ov && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                n_vec++; if ({a22, a23} !== exp) begin n_bad++;
                    $display("FAIL bp data #%0d: got %h want %h", got, {a22, a23}, exp); end
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_vec++; if (got != 20) begin n_bad++;
            $display("FAIL bp results received: got %0d want 20", got); end
        @(posedge clk); #1;
        n_vec++; if (a_cnt !== 16'd20) begin n_bad++;
            $display("FAIL bp vec_cnt: got %0d want 20", a_cnt); end
    endtask

    task automatic test_bubbles;
        logic       pv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       ea, eb;
        logic [15:0] exp;
        exp = c17m(8'h0F, 8'h33, 8'h55, 8'hF0, 8'hC3);
        do_reset;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            ea = (c >= 3 && c < 8) ? pv[c-3] : 1'b0;
            eb = (c >= 5 && c < 10) ? pv[c-5] : 1'b0;
            n_vec++; if (a_ov !== ea) begin n_bad++;
                $display("FAIL bub a out_valid c=%0d: got %b want %b", c, a_ov, ea); end
            n_vec++; if (b_ov !== eb) begin n_bad++;
                $display("FAIL bub b out_valid c=%0d: got %b want %b", c, b_ov, eb); end
            if (eb) begin
                n_vec++; if ({b22, b23} !== exp) begin n_bad++;
                    $display("FAIL bub b data c=%0d: got %h want %h", c, {b22, b23}, exp); end
            end
            drive(8'h0F, 8'h33, 8'h55, 8'hF0, 8'hC3, (c < 5) ? pv[c] : 1'b0);
        end
    endtask

    task automatic test_cnt_wrap;
        logic [15:0] exp;
        do_reset;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            drive(8'(c), 8'(c * 3), 8'(c * 5), 8'(c * 7), 8'(c * 11), c < 17);
        end
        @(posedge clk); #1;
        n_vec++; if (c_cnt !== 4'd1) begin n_bad++;
            $display("FAIL wrap vec_cnt: got %0d want 1", c_cnt); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            drive(8'hA5, 8'h5A, 8'hFF, 8'h0F, 8'h3C, 1'b1);
        end
        n_vec++; if (c_ov !== 1'b1) begin n_bad++;
            $display("FAIL midrst pre out_valid: got %b want 1", c_ov); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (c_ov !== 1'b0 || c22 !== 8'h00 || c23 !== 8'h00) begin n_bad++;
            $display("FAIL midrst outputs: got %b %h/%h want 0 00/00", c_ov, c22, c23); end
        n_vec++; if (c_cnt !== 4'd0) begin n_bad++;
            $display("FAIL midrst vec_cnt: got %0d want 0", c_cnt); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 1'b1);
        exp = c17m(8'h81, 8'h42, 8'h24, 8'h18, 8'hE7);
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_vec++; if (c_ov !== (c == 3)) begin n_bad++;
                $display("FAIL post-rst out_valid c=%0d: got %b want %b", c, c_ov, c == 3); end
            if (c == 3) begin
                n_vec++; if ({c22, c23} !== exp) begin n_bad++;
                    $display("FAIL post-rst data: got %h want %h", {c22, c23}, exp); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        test_reset;
        test_truth_table;
        test_backpressure;
        test_bubbles;
        test_cnt_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
